// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver: digit-select encoding,
// anode one-hot patterns, segment decode table and blank codes.
package ssd_pkg;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_sel_e;

    localparam logic [3:0] ANODE_BLANK = 4'b1111;
    localparam logic [6:0] SEG_BLANK   = 7'b1111111;

    // Active-low digit enables, indexed by digit select; entry 0 is the rightmost digit.
    localparam logic [3:0] ANODE_ON [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Active-low segments {a,b,c,d,e,f,g}, indexed by nibble value 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/bin2bcd16.sv
// Combinational 16-bit binary to four-digit BCD converter (double dabble).
// Inputs above 9999 saturate to 9999.
module bin2bcd16 (
    input  logic [15:0] binIn,
    output logic [15:0] bcdOut
);

    logic [13:0] satVal;
    logic [15:0] bcdAcc;

    always_comb begin
        satVal = (binIn > 16'd9999) ? 14'd9999 : binIn[13:0];
        bcdAcc = '0;
        // After saturation only 14 bits are significant, so 14 shift steps suffice.
        for (int unsigned i = 0; i < 14; i++) begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (bcdAcc[4*n +: 4] >= 4'd5) begin
                    bcdAcc[4*n +: 4] = bcdAcc[4*n +: 4] + 4'd3;
                end
            end
            bcdAcc = {bcdAcc[14:0], satVal[13 - i]};
        end
    end

    assign bcdOut = bcdAcc;

endmodule

// File: rtl/ssd_counter.sv
// Four-digit seven-segment scan driver: snapshots displayNumber once per scan
// and multiplexes it onto active-low anodes/segments. Define SSD_BCD_EN for decimal display.
module ssd_counter
    import ssd_pkg::*;
#(
    parameter int unsigned REFRESH_BITS = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] displayNumber,
    output logic [3:0]  anode,
    output logic [6:0]  ssdOut
);

    logic [REFRESH_BITS-1:0] refresh;
    logic [15:0]             snap;
    logic [15:0]             dispDigits;
    logic [3:0]              digit;
    digit_sel_e              sel;

    assign sel = digit_sel_e'(refresh[REFRESH_BITS-1 -: 2]);

`ifdef SSD_BCD_EN
    bin2bcd16 u_bin2bcd16 (
        .binIn  (snap),
        .bcdOut (dispDigits)
    );
`else
    assign dispDigits = snap;
`endif

    always_comb begin
        digit = dispDigits[3:0];
        unique case (sel)
            DIG0: digit = dispDigits[3:0];
            DIG1: digit = dispDigits[7:4];
            DIG2: digit = dispDigits[11:8];
            DIG3: digit = dispDigits[15:12];
            default: digit = dispDigits[3:0];
        endcase
    end

    // Outputs decode the pre-load snap, so the new value shows one cycle after the wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refresh <= '0;
            snap    <= '0;
            anode   <= ANODE_BLANK;
            ssdOut  <= SEG_BLANK;
        end else begin
            refresh <= refresh + REFRESH_BITS'(1);
            if (refresh == '0) begin
                snap <= displayNumber;
            end
            anode  <= ANODE_ON[sel];
            ssdOut <= SEG_TABLE[digit];
        end
    end

endmodule

// File: tb/tb_ssd_counter.sv
// Self-checking bench for ssd_counter with a 4-bit refresh counter (4 cycles per digit).
module tb_ssd_counter;

    localparam int RB = 4;
    localparam int SCAN = 1 << RB;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] displayNumber = 16'h0000;
    logic [3:0]  anode;
    logic [6:0]  ssdOut;

    ssd_counter #(.REFRESH_BITS(RB)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .displayNumber (displayNumber),
        .anode         (anode),
        .ssdOut        (ssdOut)
    );

    always #5 clk = ~clk;

    logic [6:0] segRef [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct {
        string       name;
        logic [15:0] num;
        int          sel;
        logic [3:0]  an;
        logic [6:0]  seg;
    } vec_t;

    vec_t vecs[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: cycle position in the scan, latched value, expected registered outputs.
    int          mRefresh;
    logic [15:0] mSnap;
    logic [3:0]  expAnode;
    logic [6:0]  expSeg;

`ifdef SSD_BCD_EN
    localparam logic [6:0] HOLD_SEG2 = 7'b0100000; // 16'h1234 = 4660 -> '6'
    localparam logic [6:0] OLD_SEG0  = 7'b0000001; // '0'
    localparam logic [6:0] NEW_SEG0  = 7'b0000100; // 16'h5678 saturates -> '9'
`else
    localparam logic [6:0] HOLD_SEG2 = 7'b0010010; // '2'
    localparam logic [6:0] OLD_SEG0  = 7'b1001100; // '4'
    localparam logic [6:0] NEW_SEG0  = 7'b0000000; // '8'
`endif

    function automatic int digitOf(input logic [15:0] v, input int sel);
`ifdef SSD_BCD_EN
        int d = (int'(v) > 9999) ? 9999 : int'(v);
        for (int k = 0; k < sel; k++) d = d / 10;
        return d % 10;
`else
        return (int'(v) >> (4 * sel)) % 16;
`endif
    endfunction

    task automatic modelReset();
        mRefresh = 0;
        mSnap    = 16'h0000;
        expAnode = 4'b1111;
        expSeg   = 7'b1111111;
    endtask

    task automatic check(input string name, input logic [3:0] ea, input logic [6:0] es);
        vectors++;
        if (anode !== ea || ssdOut !== es) begin
            miscompares++;
            $display("FAIL %s: got anode=%b ssdOut=%b, expected anode=%b ssdOut=%b",
                     name, anode, ssdOut, ea, es);
        end
    endtask

    // One clock: the model advances on the active edge, the caller samples at the falling edge.
    task automatic tick();
        int sel;
        @(posedge clk);
        if (reset_n) begin
            sel      = mRefresh / (SCAN / 4);
            expAnode = 4'b1111 ^ (4'b0001 << sel);
            expSeg   = segRef[digitOf(mSnap, sel)];
            if (mRefresh == 0) mSnap = displayNumber;
            mRefresh = (mRefresh + 1) % SCAN;
        end
        @(negedge clk);
    endtask

    task automatic goToSel(input int s);
        int n = 0;
        do begin
            tick();
            n++;
        end while (mRefresh != (SCAN / 4) * s + 1 && n < 2 * SCAN);
        if (mRefresh != (SCAN / 4) * s + 1) begin
            vectors++;
            miscompares++;
            $display("FAIL goToSel timeout: got refresh=%0d, expected %0d", mRefresh, (SCAN / 4) * s + 1);
        end
    endtask

    task automatic resetAndLoad(input logic [15:0] num);
        reset_n = 1'b0;
        displayNumber = num;
        #1;
        modelReset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (SCAN) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        modelReset();
`ifdef SSD_BCD_EN
        vecs.push_back('{"bcd1234_d0", 16'd1234, 0, 4'b1110, 7'b1001100});
        vecs.push_back('{"bcd1234_d1", 16'd1234, 1, 4'b1101, 7'b0000110});
        vecs.push_back('{"bcd1234_d2", 16'd1234, 2, 4'b1011, 7'b0010010});
        vecs.push_back('{"bcd1234_d3", 16'd1234, 3, 4'b0111, 7'b1001111});
        for (int s = 0; s < 4; s++)
            vecs.push_back('{"bcd_sat", 16'd40000, s, 4'b1111 ^ (4'b0001 << s), 7'b0000100});
        for (int d = 0; d < 10; d++)
            vecs.push_back('{"bcd_decode", 16'(d), 0, 4'b1110, segRef[d]});
`else
        vecs.push_back('{"hex1A2F_d0", 16'h1A2F, 0, 4'b1110, 7'b0111000});
        vecs.push_back('{"hex1A2F_d1", 16'h1A2F, 1, 4'b1101, 7'b0010010});
        vecs.push_back('{"hex1A2F_d2", 16'h1A2F, 2, 4'b1011, 7'b0001000});
        vecs.push_back('{"hex1A2F_d3", 16'h1A2F, 3, 4'b0111, 7'b1001111});
        for (int d = 0; d < 16; d++)
            vecs.push_back('{"hex_decode", 16'(d), 0, 4'b1110, segRef[d]});
`endif

        // Reset held, then released with 0.
        reset_n = 1'b0;
        displayNumber = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_hold", 4'b1111, 7'b1111111);
        reset_n = 1'b1;
        tick();
        check("reset_release", 4'b1110, 7'b0000001);

        // Table-driven digit checks.
        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0 || vecs[i].num != vecs[i-1].num || vecs[i].sel <= vecs[i-1].sel)
                resetAndLoad(vecs[i].num);
            goToSel(vecs[i].sel);
            check(vecs[i].name, vecs[i].an, vecs[i].seg);
        end

        // Snapshot hold: input change at refresh 5 waits for the next wrap.
        resetAndLoad(16'h1234);
        repeat (5) tick();
        displayNumber = 16'h5678;
        goToSel(2);
        check("snap_hold", 4'b1011, HOLD_SEG2);
        goToSel(0);
        check("snap_wrap_old", 4'b1110, OLD_SEG0);
        tick();
        check("snap_wrap_new", 4'b1110, NEW_SEG0);
        for (int k = 0; k < 2 * SCAN; k++) begin
            tick();
            check("snap_model", expAnode, expSeg);
        end

        // Reset mid-scan at refresh 9.
        for (int k = 0; k < 2 * SCAN && mRefresh != 9; k++) tick();
        reset_n = 1'b0;
        #1;
        modelReset();
        check("midscan_blank", 4'b1111, 7'b1111111);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("midscan_restart", 4'b1110, 7'b0000001);

        // Randomized run against the reference model.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 7) == 0)
                displayNumber = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 9999)) : 16'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                reset_n = 1'b0;
                #1;
                modelReset();
                check("random_reset", expAnode, expSeg);
                @(negedge clk);
                reset_n = 1'b1;
            end else begin
                tick();
                check("random", expAnode, expSeg);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
